reg_file_2r1w: RTL

//   Parametrised general-purpose register file: two registered read ports, one write port.

---
 rtl/reg_file_2r1w_if.sv | 28 ++
 rtl/reg_file_2r1w.sv | 118 +++++++++++
 2 files changed

// File: rtl/reg_file_2r1w_if.sv
// Register-file access bundle: two read ports, one write port, and status flags.
// The core's decode/writeback side is the master and the register file is the slave.
interface reg_file_2r1w_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5
);
  logic                     rd_en_a;
  logic [REG_IDX_WIDTH-1:0] rd_idx_a;
  logic [DATA_WIDTH-1:0]    rd_data_a;
  logic                     rd_en_b;
  logic [REG_IDX_WIDTH-1:0] rd_idx_b;
  logic [DATA_WIDTH-1:0]    rd_data_b;
  logic                     wr_en;
  logic [REG_IDX_WIDTH-1:0] wr_idx;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     wr_drop;
  logic                     init_busy;

  modport master (
    output rd_en_a, rd_idx_a, rd_en_b, rd_idx_b, wr_en, wr_idx, wr_data,
    input  rd_data_a, rd_data_b, wr_drop, init_busy
  );

  modport slave (
    input  rd_en_a, rd_idx_a, rd_en_b, rd_idx_b, wr_en, wr_idx, wr_data,
    output rd_data_a, rd_data_b, wr_drop, init_busy
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// General-purpose register file with two registered read ports and one write port.
// After reset, a sequencer zeroes one entry per cycle while init_busy is high.
module reg_file_2r1w #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int REG_COUNT     = 32,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  reg_file_2r1w_if.slave  bus
);

  localparam logic [REG_IDX_WIDTH:0]   COUNT = (REG_IDX_WIDTH+1)'(REG_COUNT);
  localparam logic [REG_IDX_WIDTH-1:0] LAST  = REG_IDX_WIDTH'(REG_COUNT - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e                   state_q, state_d;
  logic [REG_IDX_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic                     busy_q, busy_d;
  logic                     drop_q, drop_d;
  logic [DATA_WIDTH-1:0]    rd_a_q, rd_a_d;
  logic [DATA_WIDTH-1:0]    rd_b_q, rd_b_d;
  logic [DATA_WIDTH-1:0]    mem_q [REG_COUNT];

  logic                     mem_we;
  logic [REG_IDX_WIDTH-1:0] mem_widx;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     wr_ok;

  function automatic logic in_range(input logic [REG_IDX_WIDTH-1:0] idx);
    return {1'b0, idx} < COUNT;
  endfunction

  function automatic logic is_zero(input logic [REG_IDX_WIDTH-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Forwarding only applies to a write that will actually land in the array.
  function automatic logic [DATA_WIDTH-1:0] read_sel(input logic [REG_IDX_WIDTH-1:0] idx,
                                                     input logic                     wok,
                                                     input logic [REG_IDX_WIDTH-1:0] widx,
                                                     input logic [DATA_WIDTH-1:0]    wdata,
                                                     input logic [DATA_WIDTH-1:0]    stored);
    if (!in_range(idx) || is_zero(idx)) return '0;
    if ((BYPASS != 0) && wok && (widx == idx)) return wdata;
    return stored;
  endfunction

  assign wr_ok = bus.wr_en && in_range(bus.wr_idx) && !is_zero(bus.wr_idx);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    drop_d    = 1'b0;
    rd_a_d    = rd_a_q;
    rd_b_d    = rd_b_q;
    mem_we    = 1'b0;
    mem_widx  = bus.wr_idx;
    mem_wdata = bus.wr_data;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx_q;
        mem_wdata = '0;
        drop_d    = bus.wr_en;
        if (bus.rd_en_a) rd_a_d = '0;
        if (bus.rd_en_b) rd_b_d = '0;
        if (clr_idx_q == LAST) begin
          state_d = READY;
          busy_d  = 1'b0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      READY: begin
        mem_we = wr_ok;
        drop_d = bus.wr_en && !in_range(bus.wr_idx);
        if (bus.rd_en_a)
          rd_a_d = read_sel(bus.rd_idx_a, wr_ok, bus.wr_idx, bus.wr_data, mem_q[bus.rd_idx_a]);
        if (bus.rd_en_b)
          rd_b_d = read_sel(bus.rd_idx_b, wr_ok, bus.wr_idx, bus.wr_data, mem_q[bus.rd_idx_b]);
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
      drop_q    <= 1'b0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
    end
  end

  // The array is left untouched during the reset cycle itself.
  always_ff @(posedge sys_clk) begin
    if (sys_rst && mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  assign bus.rd_data_a = rd_a_q;
  assign bus.rd_data_b = rd_b_q;
  assign bus.wr_drop   = drop_q;
  assign bus.init_busy = busy_q;

endmodule
